gray_pixel_feeder: RTL and testbench
====================================

GRAY_PIXEL_FEEDER -- requirements
Module: gray_pixel_feeder

Interface
REQ-001 Parameter IMG_WIDTH, default 960, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 540, active lines per frame.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 enable  input  1  1 = accept stream beats; 0 = pause.
REQ-006 s_valid  input  1  source beat valid.
REQ-007 s_ready  output  1  block accepts beat this cycle.
REQ-008 s_data  input  24  RGB888 pixel, R=[23:16], G=[15:8], B=[7:0].
REQ-009 s_sof  input  1  beat is first pixel of frame.
REQ-010 s_eol  input  1  beat is last pixel of line.
REQ-011 pixel_out  output  8  grayscale pixel for the Sobel stage.
REQ-012 x_pos  output  10  column of pixel_out.
REQ-013 y_pos  output  10  row of pixel_out.
REQ-014 valid_out  output  1  pixel_out/x_pos/y_pos valid.
REQ-015 frame_done  output  1  one-cycle pulse with last pixel of frame.
REQ-016 sync_err  output  1  one-cycle pulse on framing error.
REQ-017 frame_cnt  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-018 Beat accepted when s_valid && s_ready; s_ready = enable (no downstream backpressure).
REQ-019 FSM states SEEK and ACTIVE; SEEK after reset.
REQ-020 SEEK: accepted beats without s_sof discarded (no valid_out); beat with s_sof -> emitted as (0,0), go ACTIVE.
REQ-021 ACTIVE: each accepted beat takes next raster position; x increments, at x=IMG_WIDTH-1 wraps to 0 and y increments.
REQ-022 Gray = (77*R + 150*G + 29*B) >> 8, 16-bit unsigned intermediate, no rounding, no saturation needed (max 255).
REQ-023 Latency exactly 2 cycles from accepting edge to valid_out; x_pos/y_pos/frame_done pipelined alongside.
REQ-024 valid_out high exactly one cycle per emitted beat; outputs hold last values when valid_out low.
REQ-025 Last pixel (IMG_WIDTH-1, IMG_HEIGHT-1) with s_eol: emitted, frame_done pulses with it, frame_cnt increments same cycle, go SEEK.
REQ-026 s_eol at x != IMG_WIDTH-1, or missing s_eol at x = IMG_WIDTH-1: beat still emitted, sync_err pulses aligned with it, go SEEK.
REQ-027 s_sof in ACTIVE: sync_err pulses (aligned with that beat's output), beat emitted as (0,0), remain ACTIVE; frame_cnt unchanged.
REQ-028 s_sof and s_eol on same beat: treated as sof; eol checked at x=0 (error unless IMG_WIDTH=1).
REQ-029 enable low mid-frame: position, state, pipeline contents kept; in-flight beats still drain at 2-cycle latency.
REQ-030 sync_err and frame_done never both high for same beat; error takes priority.

Reset
REQ-031 rst low: immediately state=SEEK, counters 0, pipeline valids 0, pixel_out/x_pos/y_pos/frame_cnt 0, valid_out/frame_done/sync_err 0, s_ready 0.
REQ-032 Reset mid-frame discards in-flight beats; no valid_out until a new s_sof beat is accepted after release.

Verification
REQ-033 Beat RGB=(255,255,255) with sof -> 2 cycles later valid_out=1, pixel_out=255, x_pos=0, y_pos=0.
REQ-034 RGB=(100,0,0),(0,100,0),(0,0,100) -> pixel_out 30, 58, 11.
REQ-035 Full 960x540 frame, eol every 960th beat -> x wraps 959->0, y 0..539, frame_done once with (959,539), frame_cnt 0->1, no sync_err.
REQ-036 3 beats without sof after reset, then sof beat -> no valid_out for first 3; fourth emitted at (0,0).
REQ-037 s_eol on beat x=500 -> that beat emitted with sync_err=1; subsequent non-sof beats dropped.
REQ-038 rst low at y=10 mid-line with 2 beats in flight -> valid_out 0 immediately, frame_cnt 0, s_ready 0 until release.

Source files
------------

// File: rtl/gray_pixel_feeder.sv
// gray_pixel_feeder: RGB888 stream to grayscale raster with framing checks.
// Two-cycle pipeline tags every emitted pixel with its (x,y), frame_done and sync_err.
module gray_pixel_feeder #(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 540
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic [7:0]  pixel_out,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        valid_out,
  output logic        frame_done,
  output logic        sync_err,
  output logic [15:0] frame_cnt
);
  typedef enum logic {SEEK, ACTIVE} state_t;
  localparam logic [9:0] XL = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] YL = 10'(IMG_HEIGHT - 1);
  state_t state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, px, py;
  logic acc, emit, last_col, eol_err, last, err, done;
  logic v1_q, done1_q, err1_q, v2_q, done2_q, err2_q;
  logic [23:0] rgb1_q;
  logic [9:0] x1_q, y1_q, x2_q, y2_q, xo_q, yo_q;
  logic [7:0] gray2_q, pix_q;
  logic vo_q, fd_q, se_q;
  logic [15:0] cnt_q, sum;
  assign s_ready = enable & rst;
  always_comb begin
    acc      = s_valid && s_ready;
    emit     = acc && (s_sof || state_q == ACTIVE);
    px       = s_sof ? '0 : x_q;
    py       = s_sof ? '0 : y_q;
    last_col = px == XL;
    eol_err  = s_eol != last_col;
    last     = last_col && s_eol && py == YL;
    err      = eol_err || (s_sof && state_q == ACTIVE);
    done     = last && !err;
    state_d  = emit ? ((eol_err || last) ? SEEK : ACTIVE) : state_q;
    x_d      = emit ? ((eol_err || last || last_col) ? '0 : px + 10'd1) : x_q;
    y_d      = emit ? ((eol_err || last) ? '0 : last_col ? py + 10'd1 : py) : y_q;
  end
  assign sum = 16'd77 * {8'd0, rgb1_q[23:16]} + 16'd150 * {8'd0, rgb1_q[15:8]}
             + 16'd29 * {8'd0, rgb1_q[7:0]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEEK;
      x_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  // Stage 1 captures the beat and its tags; stage 2 holds the luma result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      rgb1_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      done1_q <= 1'b0;
      err1_q <= 1'b0;
      v2_q <= 1'b0;
      gray2_q <= '0;
      x2_q <= '0;
      y2_q <= '0;
      done2_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      v1_q <= emit;
      if (emit) begin
        rgb1_q <= s_data;
        x1_q <= px;
        y1_q <= py;
        done1_q <= done;
        err1_q <= err;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        gray2_q <= sum[15:8];
        x2_q <= x1_q;
        y2_q <= y1_q;
        done2_q <= done1_q;
        err2_q <= err1_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vo_q <= 1'b0;
      fd_q <= 1'b0;
      se_q <= 1'b0;
      pix_q <= '0;
      xo_q <= '0;
      yo_q <= '0;
      cnt_q <= '0;
    end else begin
      vo_q <= v2_q;
      fd_q <= v2_q && done2_q;
      se_q <= v2_q && err2_q;
      if (v2_q) begin
        pix_q <= gray2_q;
        xo_q <= x2_q;
        yo_q <= y2_q;
      end
      if (v2_q && done2_q) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign valid_out  = vo_q;
  assign frame_done = fd_q;
  assign sync_err   = se_q;
  assign pixel_out  = pix_q;
  assign x_pos      = xo_q;
  assign y_pos      = yo_q;
  assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_gray_pixel_feeder.sv
// tb_gray_pixel_feeder: randomized stream against a raster-level model with a queue scoreboard.
module tb_gray_pixel_feeder;
  localparam int W = 16;
  localparam int H = 8;
  logic clk = 0, rst = 0, enable = 0, s_valid = 0, s_sof = 0, s_eol = 0;
  logic [23:0] s_data = '0;
  logic s_ready, valid_out, frame_done, sync_err;
  logic [7:0] pixel_out;
  logic [9:0] x_pos, y_pos;
  logic [15:0] frame_cnt;
  gray_pixel_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .pixel_out(pixel_out),
    .x_pos(x_pos), .y_pos(y_pos), .valid_out(valid_out), .frame_done(frame_done),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {int pix; int x; int y; bit done; bit err; int cnt; longint due;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  longint cyc = 0;
  bit act = 0;
  int mx = 0, my = 0, ecnt = 0, px, py, idx;
  bit lc, mis, fin, bad;
  function automatic int gray(logic [23:0] d);
    return (77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0])) / 256;
  endfunction
  task automatic chk(string n, longint a, longint x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, a, x, cyc);
    end
  endtask
  // Reference: raster position as a linear pixel index, frames start only on sof.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
      act = 0;
      ecnt = 0;
    end else if (enable && s_valid && (s_sof || act)) begin
      px = s_sof ? 0 : mx;
      py = s_sof ? 0 : my;
      lc = px == W - 1;
      mis = s_eol != lc;
      fin = s_eol && lc && py == H - 1;
      bad = mis || (s_sof && act);
      if (fin && !bad) ecnt = (ecnt + 1) % 65536;
      q.push_back('{gray(s_data), px, py, fin && !bad, bad, ecnt, cyc + 2});
      if (mis || fin) act = 0;
      else begin
        act = 1;
        idx = py * W + px + 1;
        mx = idx % W;
        my = idx / W;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst)
      chk("reset_outputs", {valid_out, frame_done, sync_err, s_ready, pixel_out, x_pos, y_pos, frame_cnt}, 0);
    else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_output actual=none expected=(%0d,%0d) due %0d", e.x, e.y, e.due);
      end
      if (valid_out) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid actual=(%0d,%0d) expected=no output", x_pos, y_pos);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.due);
          chk("pixel", pixel_out, e.pix);
          chk("x_pos", x_pos, e.x);
          chk("y_pos", y_pos, e.y);
          chk("frame_done", frame_done, e.done);
          chk("sync_err", sync_err, e.err);
          chk("frame_cnt", frame_cnt, e.cnt);
        end
      end else if (frame_done || sync_err) begin
        tests++;
        fails++;
        $display("FAIL pulse_without_valid actual=%0b%0b expected=00", frame_done, sync_err);
      end
    end
  end
  task automatic send(logic [23:0] d, bit sof, bit eol);
    bit en;
    s_data = d;
    s_sof = sof;
    s_eol = eol;
    s_valid = 1;
    do begin
      en = $urandom_range(0, 7) != 0;
      enable = en;
      @(posedge clk);
      #1;
    end while (!en);
    s_valid = 0;
    enable = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 5) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask
  // kind 1 flips eol at bad_at, kind 2 forces sof there.
  task automatic frame(int kind, int bad_at);
    bit sof, eol;
    for (int i = 0; i < W * H; i++) begin
      sof = i == 0;
      eol = i % W == W - 1;
      if (i == bad_at && kind == 1) eol = !eol;
      if (i == bad_at && kind == 2) sof = 1;
      send(24'($urandom), sof, eol);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (3) send(24'($urandom), 0, 0);
    send(24'hFFFFFF, 1, 0);
    send({8'd100, 8'd0, 8'd0}, 0, 0);
    send({8'd0, 8'd100, 8'd0}, 0, 0);
    send({8'd0, 8'd0, 8'd100}, 0, 0);
    frame(0, -1);
    frame(0, -1);
    frame(1, 5);
    frame(1, W - 1);
    frame(2, 2 * W + 3);
    send(24'($urandom), 1, 1);
    frame(1, W * H - 1);
    repeat (4) frame($urandom_range(0, 2), $urandom_range(0, W * H - 1));
    for (int i = 0; i < 3 * W + 4; i++) send(24'($urandom), i == 0, i % W == W - 1);
    s_sof = 0;
    s_eol = 0;
    s_valid = 1;
    enable = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 0;
    s_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (2) send(24'($urandom), 0, 0);
    frame(0, -1);
    repeat (6) @(posedge clk);
    chk("drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
